// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate controller: FSM state
// encoding, lane direction, car ID range and request validity helpers.
package parking_pkg;

  localparam int MAX_CARS = 3;
  localparam int ID_W     = 3;

  localparam logic [ID_W-1:0] ID_MIN = 3'd1;
  localparam logic [ID_W-1:0] ID_MAX = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_GRANT = 2'd2,
    ST_GATE  = 2'd3
  } gate_state_e;

  typedef enum logic {
    DIR_ENTRY = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_e;

  function automatic logic id_in_range(input logic [ID_W-1:0] id);
    return (id >= ID_MIN) && (id <= ID_MAX);
  endfunction

  function automatic logic slot_taken(input logic [ID_W-1:0] id,
                                      input logic [MAX_CARS-1:0] occ);
    logic taken;
    case (id)
      3'd1:    taken = occ[0];
      3'd2:    taken = occ[1];
      3'd3:    taken = occ[2];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // An entry needs a free slot, an exit needs an occupied one.
  function automatic logic request_valid(input logic [ID_W-1:0] id,
                                         input logic [MAX_CARS-1:0] occ,
                                         input dir_e dir);
    return id_in_range(id) && (slot_taken(id, occ) == (dir == DIR_EXIT));
  endfunction

endpackage

// File: rtl/parking_if.sv
// Lane sensors, ID reader and parking-system handshake grouped as one bundle;
// the controller is the master, the parking system/environment the slave.
interface parking_if;
  import parking_pkg::*;

  logic                entry_sensor;
  logic                exit_sensor;
  logic [ID_W-1:0]     id_in;
  logic [MAX_CARS-1:0] occupied;
  logic                car_enter;
  logic                car_exit;
  logic [ID_W-1:0]     car_sel;
  logic                gate_open;
  logic                reject;

  modport master (
    input  entry_sensor, exit_sensor, id_in, occupied,
    output car_enter, car_exit, car_sel, gate_open, reject
  );

  modport slave (
    output entry_sensor, exit_sensor, id_in, occupied,
    input  car_enter, car_exit, car_sel, gate_open, reject
  );

endinterface

// File: rtl/parking_gate_ctrl_sensor_debounce.sv
// Two-flop synchronizer plus level debouncer for one raw sensor; emits a
// one-cycle rise pulse in the cycle the debounced level becomes 1.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_in,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q >= CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking barrier controller: debounced lane events are queued as pending
// flags, validated against slot occupancy, granted, and the gate opened.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 4,
  parameter int GATE_OPEN_CYCLES = 8
) (
  input  logic      clk,
  input  logic      reset,
  parking_if.master bus
);
  localparam int GW = $clog2(GATE_OPEN_CYCLES + 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_OPEN_CYCLES - 1);

  gate_state_e     state_q, state_d;
  dir_e            dir_q,   dir_d;
  logic [ID_W-1:0] id_q,    id_d;
  logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
  logic            pend_entry_q, pend_entry_d;
  logic            pend_exit_q,  pend_exit_d;
  logic            car_enter_q, car_enter_d;
  logic            car_exit_q,  car_exit_d;
  logic [ID_W-1:0] car_sel_q,   car_sel_d;
  logic            gate_open_q, gate_open_d;
  logic            reject_q,    reject_d;

  logic entry_rise_s, exit_rise_s;
  logic take_s, take_exit_s, take_entry_s, req_ok_s;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_entry_deb (
    .clk    (clk),
    .reset  (reset),
    .raw_in (bus.entry_sensor),
    .rise_o (entry_rise_s)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_exit_deb (
    .clk    (clk),
    .reset  (reset),
    .raw_in (bus.exit_sensor),
    .rise_o (exit_rise_s)
  );

  // Exit wins when both lanes are waiting.
  assign take_s       = (state_q == ST_IDLE) && (pend_entry_q || pend_exit_q);
  assign take_exit_s  = take_s && pend_exit_q;
  assign take_entry_s = take_s && !pend_exit_q && pend_entry_q;
  assign req_ok_s     = request_valid(id_q, bus.occupied, dir_q);

  // State register plus datapath and output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_ENTRY;
      id_q         <= '0;
      gate_cnt_q   <= '0;
      pend_entry_q <= 1'b0;
      pend_exit_q  <= 1'b0;
      car_enter_q  <= 1'b0;
      car_exit_q   <= 1'b0;
      car_sel_q    <= '0;
      gate_open_q  <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      id_q         <= id_d;
      gate_cnt_q   <= gate_cnt_d;
      pend_entry_q <= pend_entry_d;
      pend_exit_q  <= pend_exit_d;
      car_enter_q  <= car_enter_d;
      car_exit_q   <= car_exit_d;
      car_sel_q    <= car_sel_d;
      gate_open_q  <= gate_open_d;
      reject_q     <= reject_d;
    end
  end

  // Next-state, request latch, gate timer and pending flags.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    id_d       = id_q;
    gate_cnt_d = gate_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          id_d    = bus.id_in;
          dir_d   = pend_exit_q ? DIR_EXIT : DIR_ENTRY;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: state_d = req_ok_s ? ST_GRANT : ST_IDLE;
      ST_GRANT: begin
        state_d    = ST_GATE;
        gate_cnt_d = GATE_LAST;
      end
      ST_GATE: begin
        if (gate_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q - GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_entry_d = (pend_entry_q && !take_entry_s) || entry_rise_s;
    pend_exit_d  = (pend_exit_q  && !take_exit_s)  || exit_rise_s;
  end

  // Registered outputs, aligned with the state being entered.
  always_comb begin
    car_enter_d = (state_d == ST_GRANT) && (dir_q == DIR_ENTRY);
    car_exit_d  = (state_d == ST_GRANT) && (dir_q == DIR_EXIT);
    gate_open_d = (state_d == ST_GATE);
    reject_d    = (state_q == ST_CHECK) && !req_ok_s;
    if (state_d == ST_GRANT) begin
      car_sel_d = id_q;
    end else begin
      car_sel_d = car_sel_q;
    end
  end

  assign bus.car_enter = car_enter_q;
  assign bus.car_exit  = car_exit_q;
  assign bus.car_sel   = car_sel_q;
  assign bus.gate_open = gate_open_q;
  assign bus.reject    = reject_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: a transaction-level model predicts
// every output each cycle, and literal latencies/counts pin the model.
module tb_parking_gate_ctrl;

  localparam int D = 4;
  localparam int G = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  parking_if bus();

  parking_gate_ctrl #(.DEBOUNCE_CYCLES(D), .GATE_OPEN_CYCLES(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int n_enter = 0, n_exit = 0, n_reject = 0, n_gate = 0;
  int last_enter_cyc = -1, last_exit_cyc = -1;

  // model state
  bit       h1 [2];
  bit       h2 [2];
  bit       sh [2][D];
  int       nfill [2];
  bit       lvl [2];
  bit       rise_prev [2];
  bit       flag [2];
  bit       busy;
  int       check_at, next_take;
  bit       t_dir;
  logic [2:0] t_id;
  logic [2:0] exp_sel;
  bit       exp_enter, exp_exit, exp_rej;
  int       gate_from, gate_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      h1[s] = 1'b0; h2[s] = 1'b0; nfill[s] = 0; lvl[s] = 1'b0;
      rise_prev[s] = 1'b0; flag[s] = 1'b0;
      for (int i = 0; i < D; i++) sh[s][i] = 1'b0;
    end
    busy = 1'b0; check_at = 0; next_take = 0;
    t_dir = 1'b0; t_id = 3'd0; exp_sel = 3'd0;
    exp_enter = 1'b0; exp_exit = 1'b0; exp_rej = 1'b0;
    gate_from = 0; gate_to = -1;
  endtask

  function automatic bit req_ok(input logic [2:0] id, input logic [2:0] occ, input bit is_exit);
    if (id < 3'd1 || id > 3'd3) return 1'b0;
    return occ[id - 3'd1] == is_exit;
  endfunction

  // One clock edge of the specification's behaviour, given inputs sampled now.
  task automatic model_step();
    bit nrise [2];
    bit all_diff;
    bit raw_now;
    for (int s = 0; s < 2; s++) begin
      raw_now = (s == 0) ? bus.entry_sensor : bus.exit_sensor;
      for (int i = D - 1; i > 0; i--) sh[s][i] = sh[s][i-1];
      sh[s][0] = h2[s];
      if (nfill[s] < D) nfill[s]++;
      all_diff = 1'b1;
      for (int i = 0; i < D; i++) if (sh[s][i] == lvl[s]) all_diff = 1'b0;
      nrise[s] = 1'b0;
      if (nfill[s] == D && all_diff) begin
        lvl[s] = ~lvl[s];
        nfill[s] = 0;
        nrise[s] = lvl[s];
      end
      h2[s] = h1[s];
      h1[s] = raw_now;
    end
    exp_enter = 1'b0; exp_exit = 1'b0; exp_rej = 1'b0;
    if (busy && check_at == cyc) begin
      busy = 1'b0;
      if (req_ok(t_id, bus.occupied, t_dir)) begin
        if (t_dir) exp_exit = 1'b1; else exp_enter = 1'b1;
        exp_sel = t_id;
        gate_from = cyc + 1;
        gate_to = cyc + G;
        next_take = cyc + G + 2;
      end else begin
        exp_rej = 1'b1;
        next_take = cyc + 1;
      end
    end else if (!busy && cyc >= next_take && (flag[0] || flag[1])) begin
      t_dir = flag[1];
      t_id = bus.id_in;
      flag[t_dir] = 1'b0;
      busy = 1'b1;
      check_at = cyc + 1;
    end
    for (int s = 0; s < 2; s++) begin
      flag[s] = flag[s] | rise_prev[s];
      rise_prev[s] = nrise[s];
    end
  endtask

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      model_reset();
      chk("rst_car_enter", {31'd0, bus.car_enter}, 32'd0);
      chk("rst_car_exit",  {31'd0, bus.car_exit},  32'd0);
      chk("rst_car_sel",   {29'd0, bus.car_sel},   32'd0);
      chk("rst_gate_open", {31'd0, bus.gate_open}, 32'd0);
      chk("rst_reject",    {31'd0, bus.reject},    32'd0);
    end else begin
      cyc++;
      model_step();
      chk("car_enter", {31'd0, bus.car_enter}, {31'd0, exp_enter});
      chk("car_exit",  {31'd0, bus.car_exit},  {31'd0, exp_exit});
      chk("car_sel",   {29'd0, bus.car_sel},   {29'd0, exp_sel});
      chk("gate_open", {31'd0, bus.gate_open}, {31'd0, (cyc >= gate_from && cyc <= gate_to)});
      chk("reject",    {31'd0, bus.reject},    {31'd0, exp_rej});
      if (bus.car_enter) begin n_enter++; last_enter_cyc = cyc; end
      if (bus.car_exit)  begin n_exit++;  last_exit_cyc  = cyc; end
      if (bus.reject)    n_reject++;
      if (bus.gate_open) n_gate++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise a sensor for `len` cycles starting at the current negedge.
  task automatic pulse(input bit is_exit, input int len, output int t0);
    t0 = cyc;
    if (is_exit) bus.exit_sensor = 1'b1; else bus.entry_sensor = 1'b1;
    wait_n(len);
    if (is_exit) bus.exit_sensor = 1'b0; else bus.entry_sensor = 1'b0;
  endtask

  int t0, c1, b_en, b_ex, b_rj, b_gt;

  initial begin
    reset = 1'b0;
    bus.entry_sensor = 1'b0;
    bus.exit_sensor  = 1'b0;
    bus.id_in        = 3'd0;
    bus.occupied     = 3'd0;
    #1;
    chk("t0_gate_open", {31'd0, bus.gate_open}, 32'd0);
    chk("t0_car_sel",   {29'd0, bus.car_sel},   32'd0);
    wait_n(3);
    reset = 1'b1;
    wait_n(2);

    // single valid entry
    bus.occupied = 3'b000; bus.id_in = 3'd2;
    b_en = n_enter; b_gt = n_gate; b_rj = n_reject;
    pulse(1'b0, 10, t0);
    wait_n(30);
    chk("A_enter_count", n_enter - b_en, 32'd1);
    chk("A_grant_latency", last_enter_cyc - t0, 32'd9);
    chk("A_car_sel", {29'd0, bus.car_sel}, 32'd2);
    chk("A_gate_cycles", n_gate - b_gt, 32'd8);
    chk("A_no_reject", n_reject - b_rj, 32'd0);

    // bouncing sensor
    b_en = n_enter; b_gt = n_gate;
    for (int i = 0; i < 10; i++) begin
      bus.entry_sensor = ~bus.entry_sensor;
      wait_n(2);
    end
    bus.entry_sensor = 1'b0;
    wait_n(25);
    chk("B_no_enter", n_enter - b_en, 32'd0);
    chk("B_no_gate", n_gate - b_gt, 32'd0);

    // occupied slot: entry refused, exit granted
    bus.occupied = 3'b001; bus.id_in = 3'd1;
    b_en = n_enter; b_rj = n_reject; b_ex = n_exit;
    pulse(1'b0, 6, t0);
    wait_n(25);
    chk("C_entry_reject", n_reject - b_rj, 32'd1);
    chk("C_no_enter", n_enter - b_en, 32'd0);
    pulse(1'b1, 6, t0);
    wait_n(30);
    chk("C_exit_count", n_exit - b_ex, 32'd1);
    chk("C_exit_latency", last_exit_cyc - t0, 32'd9);
    chk("C_exit_sel", {29'd0, bus.car_sel}, 32'd1);

    // invalid IDs
    b_rj = n_reject; b_en = n_enter;
    bus.id_in = 3'd0;
    pulse(1'b0, 6, t0);
    wait_n(25);
    bus.id_in = 3'd7;
    pulse(1'b0, 6, t0);
    wait_n(25);
    chk("D_rejects", n_reject - b_rj, 32'd2);
    chk("D_no_enter", n_enter - b_en, 32'd0);
    chk("D_sel_held", {29'd0, bus.car_sel}, 32'd1);

    // simultaneous entry and exit, slot freed during gate
    bus.id_in = 3'd3; bus.occupied = 3'b100;
    b_en = n_enter; b_ex = n_exit; b_rj = n_reject;
    t0 = cyc;
    bus.entry_sensor = 1'b1; bus.exit_sensor = 1'b1;
    wait_n(10);
    bus.entry_sensor = 1'b0; bus.exit_sensor = 1'b0;
    wait_n(2);
    bus.occupied = 3'b000;
    wait_n(30);
    chk("E_exit_first", last_exit_cyc - t0, 32'd9);
    chk("E_entry_after_gate", last_enter_cyc - t0, 32'd20);
    chk("E_counts", (n_enter - b_en) * 16 + (n_exit - b_ex), 32'd17);
    chk("E_no_reject", n_reject - b_rj, 32'd0);
    chk("E_sel", {29'd0, bus.car_sel}, 32'd3);

    // reset during the 4th gate cycle, sensor held high throughout
    bus.id_in = 3'd1; bus.occupied = 3'b000;
    t0 = cyc;
    bus.entry_sensor = 1'b1;
    wait_n(13);
    chk("F_gate_4th", {31'd0, bus.gate_open}, 32'd1);
    reset = 1'b0;
    #1;
    chk("F_rst_gate_open", {31'd0, bus.gate_open}, 32'd0);
    chk("F_rst_car_sel",   {29'd0, bus.car_sel},   32'd0);
    chk("F_rst_others",    {29'd0, bus.car_enter, bus.car_exit, bus.reject}, 32'd0);
    wait_n(2);
    reset = 1'b1;
    c1 = cyc; b_en = n_enter;
    wait_n(8);
    chk("F_quiet_after_release", n_enter - b_en, 32'd0);
    wait_n(3);
    chk("F_fresh_event", n_enter - b_en, 32'd1);
    chk("F_fresh_latency", last_enter_cyc - c1, 32'd9);
    bus.entry_sensor = 1'b0;
    wait_n(25);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a sensor level change.
REQ-002 Parameter GATE_OPEN_CYCLES, default 8: cycles gate_open stays high per accepted transaction.
REQ-003 clk  input  1  single system clock; all flops rising-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 entry_sensor  input  1  raw, asynchronous entry-lane car detector.
REQ-006 exit_sensor  input  1  raw, asynchronous exit-lane car detector.
REQ-007 id_in  input  3  car ID from reader; 1..3 valid; 0 and 4..7 invalid.
REQ-008 occupied  input  3  slot state fed back from parking system; bit0 = car1, bit1 = car2, bit2 = car3.
REQ-009 car_enter  output  1  one-cycle entry request to parking system.
REQ-010 car_exit  output  1  one-cycle exit request to parking system.
REQ-011 car_sel  output  3  car ID accompanying car_enter/car_exit.
REQ-012 gate_open  output  1  barrier drive.
REQ-013 reject  output  1  one-cycle pulse when a request is refused.

Function
REQ-014 Each sensor SHALL pass through a 2-flop synchronizer, then a debouncer that changes its level only after DEBOUNCE_CYCLES consecutive equal samples; a new event is the debounced 0->1 edge.
REQ-015 FSM states SHALL be IDLE, CHECK, GRANT, GATE, with state encoding defined in the shared package.
REQ-016 Detected events SHALL set pending_entry/pending_exit flags; an event arriving while its flag is already set SHALL be dropped.
REQ-017 IDLE: when either flag is set, latch id_in and the direction, clear that flag, and go to CHECK; exit SHALL take priority when both flags are set.
REQ-018 CHECK: entry is valid iff 1<=id<=3 and occupied[id-1]=0; exit is valid iff 1<=id<=3 and occupied[id-1]=1; valid -> GRANT, invalid -> reject=1 for one cycle and return to IDLE.
REQ-019 GRANT: car_enter or car_exit SHALL be high for exactly one cycle, never both, with car_sel = latched id in that same cycle; next state GATE.
REQ-020 car_sel SHALL hold its last granted ID until the next grant.
REQ-021 GATE: gate_open=1 for exactly GATE_OPEN_CYCLES cycles, then IDLE; events during GATE SHALL be captured in pending flags and served afterwards.
REQ-022 Latency: debounced edge at cycle N -> flag set N+1 -> CHECK N+2 -> GRANT pulse N+3 -> gate_open from N+4.
REQ-023 Debounce and gate counters SHALL saturate/reload without wrap; sensor bounce shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-024 occupied SHALL be sampled only in CHECK; changes in other states have no effect.

Reset
REQ-025 reset low SHALL immediately force IDLE, all flags 0, all counters 0, debounced levels 0, car_enter=0, car_exit=0, car_sel=0, gate_open=0, reject=0.
REQ-026 reset asserted mid-GATE or mid-GRANT SHALL abort without completing the pulse; after release, a sensor already high SHALL first debounce to 1 and then count as a new event.

Structure
REQ-027 Shared package parking_pkg SHALL hold the FSM state typedef, MAX_CARS=3, and the ID range constants.
REQ-028 Debouncing SHALL be a sub-module sensor_debounce (synchronizer + counter + edge output), instantiated twice.

Verification
REQ-029 occupied=000, id_in=2, entry_sensor high for 10 cycles -> one car_enter pulse with car_sel=010, then gate_open high for 8 cycles, reject stays 0.
REQ-030 entry_sensor toggling every 2 cycles for 20 cycles -> no car_enter, no gate_open.
REQ-031 occupied=001, id_in=1, entry event -> reject pulse, no car_enter; same with exit event -> car_exit pulse with car_sel=001.
REQ-032 id_in=0 and then id_in=7, each with an entry event -> reject each time, car_sel unchanged from its previous value.
REQ-033 Entry and exit events on the same cycle (id 3, occupied=100) -> car_exit first; entry served after GATE ends, with CHECK re-sampling occupied.
REQ-034 reset pulled low during the 4th gate_open cycle -> all outputs 0 on the same cycle; no pulse after release until a fresh debounced event.
